// File: rtl/dffre_pkg.sv
// dffre_pkg: shared width default and parity helper for dffre_reg
package dffre_pkg;
  localparam int DFFRE_DEFAULT_N = 8;
  function automatic logic parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/dffre_reg.sv
// dffre_reg: n-bit enabled register with async active-low reset
// Optional stored-parity checker when DFFRE_REG_PARITY_EN is defined.
module dffre_reg
  import dffre_pkg::*;
#(
  parameter int n = DFFRE_DEFAULT_N,
  parameter logic [n-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic [n-1:0] d,
`ifdef DFFRE_REG_PARITY_EN
  output logic         par_err,
`endif
  output logic [n-1:0] q
);
  // Ternary hold keeps an X enable from acting as 1; only differing bits go X.
  always_ff @(posedge clk or negedge r)
    if (!r) q <= RST_VAL;
    else q <= en ? d : q;
`ifdef DFFRE_REG_PARITY_EN
  if (1) begin : g_par
    logic p;
    always_ff @(posedge clk or negedge r)
      if (!r) begin
        p <= parity(64'(RST_VAL));
        par_err <= 1'b0;
      end else begin
        p <= en ? parity(64'(d)) : p;
        par_err <= parity(64'(q)) ^ p;
      end
  end
`endif
endmodule

// File: tb/tb_dffre_reg.sv
// tb_dffre_reg: directed self-checking bench for dffre_reg (n=8)
module tb_dffre_reg;
  logic clk;
  logic r;
  logic en;
  logic [7:0] d;
  logic [7:0] q;
`ifdef DFFRE_REG_PARITY_EN
  logic par_err;
`endif
  int errors = 0;
  int checks = 0;

  dffre_reg #(.n(8), .RST_VAL(8'h00)) dut (
    .clk(clk),
    .r(r),
    .en(en),
    .d(d),
`ifdef DFFRE_REG_PARITY_EN
    .par_err(par_err),
`endif
    .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    r = 1'b0;
    en = 1'b0;
    d = 8'h00;
    #1;
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL reset_imm q=%h exp=%h", q, 8'h00); end
    d = 8'h58;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (q !== 8'h00) begin errors++; $display("FAIL reset_hold%0d q=%h exp=%h", i, q, 8'h00); end
    end
  endtask

  task automatic test_enable;
    r = 1'b1;
    en = 1'b0;
    d = 8'hB2;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (q !== 8'h00) begin errors++; $display("FAIL gate%0d q=%h exp=%h", i, q, 8'h00); end
    end
    en = 1'b1;
    cyc();
    checks++;
    if (q !== 8'hB2) begin errors++; $display("FAIL gate_load q=%h exp=%h", q, 8'hB2); end
  endtask

  task automatic test_tracking;
    logic [7:0] seq [3];
    seq = '{8'h70, 8'h00, 8'h91};
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = seq[i];
      cyc();
      checks++;
      if (q !== seq[i]) begin errors++; $display("FAIL track%0d q=%h exp=%h", i, q, seq[i]); end
    end
    en = 1'b0;
    d = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (q !== 8'h91) begin errors++; $display("FAIL hold%0d q=%h exp=%h", i, q, 8'h91); end
    end
  endtask

  task automatic test_truncation;
    int di;
    di = 11111000;
    d = di[7:0];
    en = 1'b1;
    cyc();
    checks++;
    if (q !== 8'h58) begin errors++; $display("FAIL trunc q=%h exp=%h", q, 8'h58); end
  endtask

  task automatic test_async;
    en = 1'b1;
    d = 8'hB2;
    @(posedge clk);
    #2;
    checks++;
    if (q !== 8'hB2) begin errors++; $display("FAIL async_pre q=%h exp=%h", q, 8'hB2); end
    r = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL async_clr q=%h exp=%h", q, 8'h00); end
    cyc();
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL async_hold q=%h exp=%h", q, 8'h00); end
    r = 1'b1;
    #1;
    checks++;
    if (q !== 8'h00) begin errors++; $display("FAIL release q=%h exp=%h", q, 8'h00); end
    cyc();
    checks++;
    if (q !== 8'hB2) begin errors++; $display("FAIL first_cap q=%h exp=%h", q, 8'hB2); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] dv [4];
    logic       ev [4];
    logic [7:0] ex [4];
    dv = '{8'hAA, 8'h55, 8'h55, 8'hFF};
    ev = '{1'b1, 1'b0, 1'b1, 1'b1};
    ex = '{8'hAA, 8'hAA, 8'h55, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      d = dv[i];
      en = ev[i];
      cyc();
      checks++;
      if (q !== ex[i]) begin errors++; $display("FAIL b2b%0d q=%h exp=%h", i, q, ex[i]); end
    end
  endtask

`ifdef DFFRE_REG_PARITY_EN
  task automatic test_parity;
    en = 1'b1;
    d = 8'h91;
    cyc();
    en = 1'b0;
    cyc();
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("FAIL par_ok par_err=%b exp=0", par_err); end
    force dut.q = 8'h90;
    cyc();
    checks++;
    if (par_err !== 1'b1) begin errors++; $display("FAIL par_flip par_err=%b exp=1", par_err); end
    release dut.q;
    r = 1'b0;
    #1;
    checks++;
    if (par_err !== 1'b0) begin errors++; $display("FAIL par_rst par_err=%b exp=0", par_err); end
    r = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_enable();
    test_tracking();
    test_truncation();
    test_async();
    test_back_to_back();
`ifdef DFFRE_REG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
